aes_job_arbiter: RTL and testbench

//  Shares one AES_TOP encryption engine between N_REQ requesters (AXI slave channels, DMA).

---
 rtl/aes_arb_pkg.sv | 53 +++++
 rtl/aes_rr_pick.sv | 45 ++++
 rtl/aes_job_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES job arbiter: FSM states, response codes,
// job/response payloads and small helpers.
package aes_arb_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned RES_W     = 128;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned STAT_W    = 2;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned ABORT_CYC = 4;
    localparam int unsigned ABORT_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_BUSY   = 3'd3,
        ST_ABORT  = 3'd4,
        ST_RESP   = 3'd5
    } arb_state_e;

    localparam logic [STAT_W-1:0] RSP_OK      = 2'd0;
    localparam logic [STAT_W-1:0] RSP_BAD_LEN = 2'd1;
    localparam logic [STAT_W-1:0] RSP_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [IDX_W-1:0]  id;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  chunks;
    } job_t;

    typedef struct packed {
        logic [IDX_W-1:0]  id;
        logic [STAT_W-1:0] status;
        logic [RES_W-1:0]  result;
    } rsp_t;

    // Legal chunk counts are 1..max_chunks inclusive.
    function automatic logic len_ok(input logic [CNT_W-1:0] chunks,
                                    input int unsigned      max_chunks);
        return (chunks != '0) && (chunks <= CNT_W'(max_chunks));
    endfunction

    // Owner index plus one, wrapping at the requester count.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input int unsigned      n);
        int unsigned nxt;
        nxt = 32'(idx) + 32'd1;
        return (nxt >= n) ? '0 : IDX_W'(nxt);
    endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping from N_REQ-1 back to 0.
module aes_rr_pick
    import aes_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             found_c
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    // Rotate so that bit 0 of rot is the requester at the pointer.
    always_comb begin
        dbl = {req, req};
        rot = N_REQ'(dbl >> ptr);
    end

    always_comb begin
        int unsigned sum;
        grant_c = '0;
        idx_c   = '0;
        found_c = 1'b0;
        sum     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found_c && rot[k]) begin
                found_c = 1'b1;
                sum     = 32'(ptr) + k;
                if (sum >= N_REQ) begin
                    sum = sum - N_REQ;
                end
                idx_c = IDX_W'(sum);
            end
        end
        if (found_c) begin
            grant_c = N_REQ'(1) << idx_c;
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES engine between N_REQ requesters: round-robin job grant, engine launch,
// watchdog with abort, and response return to the owning requester.
module aes_job_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 1048576,
    parameter int unsigned MAX_CHUNKS  = 65536
) (
    input  logic                 aes_clk,
    input  logic                 aes_rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_addr,
    input  logic [32*N_REQ-1:0]  req_chunks,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [1:0]           rsp_status,
    output logic [127:0]         rsp_result,
    output logic                 eng_start,
    output logic [31:0]          eng_addr_start,
    output logic [31:0]          eng_num_chunks,
    input  logic                 eng_complete,
    input  logic [127:0]         eng_result,
    output logic                 eng_abort,
    output logic                 busy
);
    import aes_arb_pkg::*;

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    job_t                job_q, job_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [ABORT_W-1:0]  abort_cnt_q, abort_cnt_d;
    rsp_t                rsp_q, rsp_d;
    logic [N_REQ-1:0]    req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                eng_start_q, eng_start_d;
    logic                eng_abort_q, eng_abort_d;
    logic                busy_q, busy_d;

    logic [N_REQ-1:0]    grant_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic                found_c;

    logic [ADDR_W-1:0]   addr_arr   [MAX_REQ];
    logic [CNT_W-1:0]    chunks_arr [MAX_REQ];

    // Unpack the flat request buses; unused slots read as zero so a 3-bit index is always legal.
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_unpack
        if (g < N_REQ) begin : g_live
            assign addr_arr[g]   = req_addr[ADDR_W*g +: ADDR_W];
            assign chunks_arr[g] = req_chunks[CNT_W*g +: CNT_W];
        end else begin : g_pad
            assign addr_arr[g]   = '0;
            assign chunks_arr[g] = '0;
        end
    end

    aes_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant_c (grant_c),
        .idx_c   (pick_idx_c),
        .found_c (found_c)
    );

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        job_d       = job_q;
        wd_d        = wd_q;
        abort_cnt_d = abort_cnt_q;
        rsp_d       = rsp_q;
        req_ready_d = '0;
        eng_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (found_c) begin
                    req_ready_d  = grant_c;
                    job_d.id     = pick_idx_c;
                    job_d.addr   = addr_arr[pick_idx_c];
                    job_d.chunks = chunks_arr[pick_idx_c];
                    if (len_ok(chunks_arr[pick_idx_c], MAX_CHUNKS)) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        rsp_d.id     = pick_idx_c;
                        rsp_d.status = RSP_BAD_LEN;
                        rsp_d.result = '0;
                        state_d      = ST_RESP;
                    end
                end else begin
                    // Requester withdrew before the grant; nothing to serve.
                    state_d = ST_IDLE;
                end
            end

            ST_LAUNCH: begin
                eng_start_d = 1'b1;
                wd_d        = '0;
                state_d     = ST_BUSY;
            end

            ST_BUSY: begin
                wd_d = wd_q + WD_W'(1);
                if (eng_complete) begin
                    rsp_d.id     = job_q.id;
                    rsp_d.status = RSP_OK;
                    rsp_d.result = eng_result;
                    state_d      = ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_d.id     = job_q.id;
                    rsp_d.status = RSP_TIMEOUT;
                    rsp_d.result = '0;
                    abort_cnt_d  = '0;
                    state_d      = ST_ABORT;
                end
            end

            ST_ABORT: begin
                abort_cnt_d = abort_cnt_q + ABORT_W'(1);
                if (abort_cnt_q == ABORT_W'(ABORT_CYC - 1)) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = next_idx(job_q.id, N_REQ);
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        eng_abort_d = (state_d == ST_ABORT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge aes_clk) begin
        if (aes_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            job_q       <= '0;
            wd_q        <= '0;
            abort_cnt_q <= '0;
            rsp_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            job_q       <= job_d;
            wd_q        <= wd_d;
            abort_cnt_q <= abort_cnt_d;
            rsp_q       <= rsp_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            eng_start_q <= eng_start_d;
            eng_abort_q <= eng_abort_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_q.id;
    assign rsp_status     = rsp_q.status;
    assign rsp_result     = rsp_q.result;
    assign eng_start      = eng_start_q;
    assign eng_addr_start = job_q.addr;
    assign eng_num_chunks = job_q.chunks;
    assign eng_abort      = eng_abort_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Randomized self-checking bench for aes_job_arbiter with a transaction-level
// reference model of grant order, engine timing and response contents.
module tb_aes_job_arbiter;

    localparam int N    = 4;
    localparam int TO   = 64;
    localparam int MAXC = 65536;
    localparam int ABRT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [32*N-1:0]  req_addr;
    logic [32*N-1:0]  req_chunks;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_id;
    logic [1:0]       rsp_status;
    logic [127:0]     rsp_result;
    logic             eng_start;
    logic [31:0]      eng_addr_start;
    logic [31:0]      eng_num_chunks;
    logic             eng_complete;
    logic [127:0]     eng_result;
    logic             eng_abort;
    logic             busy;

    always #5 clk = ~clk;

    aes_job_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO),
        .MAX_CHUNKS  (MAXC)
    ) dut (
        .aes_clk        (clk),
        .aes_rst        (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_chunks     (req_chunks),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_status     (rsp_status),
        .rsp_result     (rsp_result),
        .eng_start      (eng_start),
        .eng_addr_start (eng_addr_start),
        .eng_num_chunks (eng_num_chunks),
        .eng_complete   (eng_complete),
        .eng_result     (eng_result),
        .eng_abort      (eng_abort),
        .busy           (busy)
    );

    typedef struct {
        int           id;
        logic [1:0]   status;
        logic [127:0] result;
        int           lat;
        int           due;
        logic [31:0]  addr;
        logic [31:0]  chunks;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester job tables (ring per requester)
    logic [31:0] atab [N][16];
    logic [31:0] ctab [N][16];
    int          head [N];
    int          tail [N];

    // Model state
    exp_t         exp_q[$];
    int           glog[$];
    int           cyc = 0;
    int           ptr_m = 0;
    logic [N-1:0] v_at_edge = '0;
    logic [N-1:0] ready_seen = '0;
    logic         rsp_open = 1'b0;
    int           open_id = 0;
    logic [1:0]   open_status = '0;
    logic [127:0] open_result = '0;
    logic         launch_pending = 1'b0;
    int           exp_start_cyc = -1;
    int           complete_at = -1;
    int           stray_at = -1;
    int           hold_until = 0;
    int           abort_seen = 0;
    int           n_done = 0;
    int           n_seen = 0;
    int           n_starts = 0;
    int           last_grant_cyc = -1;
    logic         lat_rand = 1'b0;
    int           next_lat = 10;
    logic         fixed_val_en = 1'b0;
    logic [127:0] fixed_val = '0;
    logic [127:0] eng_val = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -1;
        if (r == 1) return TO - 1;
        if (r == 2) return TO;
        return $urandom_range(0, 40);
    endfunction

    task automatic push(input int i, input logic [31:0] a, input logic [31:0] c);
        atab[i][4'(tail[i])] = a;
        ctab[i][4'(tail[i])] = c;
        tail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = (head[i] < tail[i]);
            req_addr[32*i +: 32]   = atab[i][4'(head[i])];
            req_chunks[32*i +: 32] = ctab[i][4'(head[i])];
        end
        eng_complete = (cyc == complete_at) || (cyc == stray_at);
        eng_result   = (cyc == complete_at) ? eng_val
                                            : {$urandom(), $urandom(), $urandom(), $urandom()};
        rsp_ready    = (cyc >= hold_until) && ($urandom_range(0, 2) != 0);
    endtask

    task automatic monitor();
        exp_t e;
        int   g;
        int   n;
        if (req_ready != '0) begin
            check("ready_onehot", 128'($onehot(req_ready)), 128'(1));
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && g < 0) g = i;
            end
            check("grant_id", 128'(g), 128'(model_pick(v_at_edge, ptr_m)));
            ready_seen     = req_ready;
            last_grant_cyc = cyc;
            glog.push_back(g);
            if (g >= 0) begin
                e.id     = g;
                e.addr   = atab[g][4'(head[g])];
                e.chunks = ctab[g][4'(head[g])];
                if (e.chunks == 0 || e.chunks > MAXC) begin
                    e.status = 2'd1;
                    e.result = '0;
                    e.lat    = -1;
                    e.due    = cyc;
                end else begin
                    e.lat    = lat_rand ? pick_lat() : next_lat;
                    e.status = (e.lat >= 0 && e.lat < TO) ? 2'd0 : 2'd2;
                    eng_val  = fixed_val_en ? fixed_val
                                            : {$urandom(), $urandom(), $urandom(), $urandom()};
                    e.result = (e.status == 2'd0) ? eng_val : '0;
                    e.due    = -1;
                    launch_pending = 1'b1;
                    exp_start_cyc  = cyc + 1;
                end
                exp_q.push_back(e);
            end
        end
        if (eng_start) begin
            check("start_expected", 128'(launch_pending), 128'(1));
            check("start_lat", 128'(cyc), 128'(exp_start_cyc));
            n_starts++;
            if (exp_q.size() > 0) begin
                n = exp_q.size() - 1;
                check("eng_addr", 128'(eng_addr_start), 128'(exp_q[n].addr));
                check("eng_chunks", 128'(eng_num_chunks), 128'(exp_q[n].chunks));
                complete_at = (exp_q[n].lat >= 0) ? cyc + exp_q[n].lat : -1;
                exp_q[n].due = (exp_q[n].status == 2'd0) ? cyc + exp_q[n].lat + 1
                                                         : cyc + TO + ABRT;
            end
            launch_pending = 1'b0;
        end
        if (eng_abort) abort_seen++;
        if (rsp_valid) begin
            if (!rsp_open) begin
                rsp_open = 1'b1;
                n_seen++;
                check("busy_in_resp", 128'(busy), 128'(1));
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 128'(exp_q.size()), 128'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 128'(rsp_id), 128'(e.id));
                    check("rsp_status", 128'(rsp_status), 128'(e.status));
                    check("rsp_result", rsp_result, e.result);
                    check("rsp_cycle", 128'(cyc), 128'(e.due));
                    check("abort_cycles", 128'(abort_seen), 128'((e.status == 2'd2) ? ABRT : 0));
                    if (e.status != 2'd1) begin
                        check("eng_addr_hold", 128'({eng_addr_start, eng_num_chunks}),
                              128'({e.addr, e.chunks}));
                    end
                end
                abort_seen  = 0;
                open_id     = rsp_id;
                open_status = rsp_status;
                open_result = rsp_result;
            end else begin
                check("rsp_stable_hdr", 128'({rsp_id, rsp_status}), 128'({open_id[2:0], open_status}));
                check("rsp_stable_res", rsp_result, open_result);
            end
        end else if (rsp_open) begin
            check("rsp_held", 128'(rsp_valid), 128'(1));
            rsp_open = 1'b0;
        end
    endtask

    task automatic step();
        logic rr;
        rr        = rsp_ready;
        v_at_edge = req_valid;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (ready_seen[i]) head[i]++;
        end
        ready_seen = '0;
        if (rsp_open && rr) begin
            rsp_open = 1'b0;
            ptr_m    = (open_id + 1) % N;
            n_done++;
        end
        #1;
        monitor();
        drive();
    endtask

    // which: 0 = responses consumed, 1 = responses seen, 2 = engine starts
    task automatic run_until(input int which, input int target, input int budget);
        int k;
        int cur;
        k   = 0;
        cur = (which == 0) ? n_done : (which == 1) ? n_seen : n_starts;
        while (cur < target && k < budget) begin
            step();
            k++;
            cur = (which == 0) ? n_done : (which == 1) ? n_seen : n_starts;
        end
        if (cur < target) check("wait_budget", 128'(cur), 128'(target));
    endtask

    task automatic check_zero();
        check("rst_ctrl", 128'({req_ready, rsp_valid, eng_start, eng_abort, busy, rsp_id, rsp_status}), 128'(0));
        check("rst_result", rsp_result, 128'(0));
        check("rst_eng_bus", 128'({eng_addr_start, eng_num_chunks}), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) head[i] = tail[i];
        ready_seen     = '0;
        rsp_open       = 1'b0;
        launch_pending = 1'b0;
        complete_at    = -1;
        stray_at       = -1;
        hold_until     = 0;
        abort_seen     = 0;
        ptr_m          = 0;
        drive();
        step();
        check_zero();
        rst = 1'b0;
        drive();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int s0;
        int t_raise;
        int gk;
        int nj;
        int sel;
        logic [31:0] c;

        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            for (int j = 0; j < 16; j++) begin
                atab[i][j] = '0;
                ctab[i][j] = '0;
            end
        end
        rst = 1'b1;
        drive();
        step();
        step();
        check_zero();
        rst = 1'b0;
        drive();
        step();

        // Single job with fixed result pattern
        fixed_val_en = 1'b1;
        fixed_val    = {16{8'hA5}};
        lat_rand     = 1'b0;
        next_lat     = 50;
        push(0, 32'h100, 32'd2);
        drive();
        t_raise = cyc;
        run_until(0, n_done + 1, 300);
        check("ready_lat", 128'(last_grant_cyc - t_raise), 128'(2));
        fixed_val_en = 1'b0;

        // Fairness: all requesters valid for 8 jobs from pointer 0
        do_reset();
        glog.delete();
        base     = n_done;
        lat_rand = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push(i, $urandom(), 32'($urandom_range(1, 1000)));
        end
        drive();
        run_until(0, base + 8, 2000);
        for (int k = 0; k < 8; k++) begin
            gk = (k < glog.size()) ? glog[k] : -1;
            check("rr_order", 128'(gk), 128'(k % N));
        end
        check("rr_responses", 128'(n_done - base), 128'(8));

        // Chunk count boundaries
        lat_rand = 1'b0;
        next_lat = 5;
        s0 = n_starts;
        push(2, 32'h2000, 32'd0);
        drive();
        run_until(0, n_done + 1, 200);
        push(2, 32'h2040, 32'(MAXC + 1));
        drive();
        run_until(0, n_done + 1, 200);
        check("badlen_no_start", 128'(n_starts), 128'(s0));
        push(2, 32'h2080, 32'(MAXC));
        drive();
        run_until(0, n_done + 1, 200);
        check("maxlen_started", 128'(n_starts), 128'(s0 + 1));

        // Watchdog expiry, then a normal job
        next_lat = -1;
        push(1, 32'h3000, 32'd7);
        drive();
        run_until(0, n_done + 1, 300);
        next_lat = 10;
        push(3, 32'h3100, 32'd9);
        drive();
        run_until(0, n_done + 1, 300);

        // Completion on the last watchdog cycle, and one cycle too late
        next_lat = TO - 1;
        push(0, 32'h4000, 32'd3);
        drive();
        run_until(0, n_done + 1, 300);
        next_lat = TO;
        push(0, 32'h4100, 32'd3);
        drive();
        run_until(0, n_done + 1, 300);
        next_lat = TO - 2;
        push(1, 32'h4200, 32'd4);
        drive();
        run_until(0, n_done + 1, 300);

        // Held response with a stray completion pulse
        next_lat   = 10;
        hold_until = cyc + 100000;
        push(1, 32'h5000, 32'd5);
        drive();
        run_until(1, n_seen + 1, 200);
        stray_at = cyc + 3;
        s0       = n_seen;
        repeat (20) step();
        check("no_second_rsp", 128'(n_seen), 128'(s0));
        check("busy_held", 128'(busy), 128'(1));
        stray_at   = -1;
        hold_until = cyc;
        drive();
        run_until(0, n_done + 1, 200);

        // Reset while the engine is running, then recover
        next_lat = -1;
        push(0, 32'h6000, 32'd8);
        drive();
        run_until(2, n_starts + 1, 100);
        repeat (10) step();
        do_reset();
        next_lat = 7;
        push(2, 32'h6100, 32'd8);
        drive();
        run_until(0, n_done + 1, 200);

        // Randomized traffic
        lat_rand = 1'b1;
        for (int round = 0; round < 10; round++) begin
            nj = $urandom_range(1, 3);
            for (int j = 0; j < nj; j++) begin
                sel = $urandom_range(0, 7);
                c   = (sel == 0) ? 32'd0 :
                      (sel == 1) ? 32'(MAXC + 1 + $urandom_range(0, 100)) :
                      (sel == 2) ? 32'(MAXC) : 32'($urandom_range(1, 4096));
                push($urandom_range(0, N - 1), $urandom(), c);
            end
            drive();
            run_until(0, n_done + nj, nj * 200);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
